// File: rtl/io_timer_regs.sv
// io_timer_regs
//
// MMIO responder on the IO side of the CPU memory fabric. It answers
// single-word requests with registered read data and a one-cycle ready
// pulse. It holds three things: an LED output register, a 2-flop
// synchronized switch input, and a 32-bit free-running timer with a
// compare-match interrupt. Only the word offset addr[4:2] is decoded,
// because the fabric has already qualified the IO window.
//
// Ports
//   clk            single clock, rising edge
//   rst            synchronous, active-high reset
//   io_mmio_req    access request, held with addr/we/wdata until ready
//   io_mmio_we     1 = write, 0 = read
//   io_mmio_addr   byte address, bits [4:2] decoded
//   io_mmio_wdata  write data
//   io_mmio_rdata  read data, valid only while ready, 0 otherwise
//   io_mmio_ready  one-cycle completion pulse
//   led_o          LED register contents
//   sw_i           asynchronous switch inputs
//   timer_irq      level interrupt = PEND & IRQ_EN
//
// Register map (word offset)
//   0 LED    RW  bits [LED_W-1:0]
//   1 SW     RO  synchronized sw_i, zero-extended
//   2 COUNT  RW  timer counter
//   3 CMP    RW  compare value
//   4 CTRL   bit0 EN, bit1 IRQ_EN, bit2 PEND (write 1 to clear)
//   5-7      reserved: reads 0, writes dropped
module io_timer_regs #(
  parameter int LED_W = 16,
  parameter int SW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             io_mmio_req,
  input  logic             io_mmio_we,
  input  logic [31:0]      io_mmio_addr,
  input  logic [31:0]      io_mmio_wdata,
  output logic [31:0]      io_mmio_rdata,
  output logic             io_mmio_ready,
  output logic [LED_W-1:0] led_o,
  input  logic [SW_W-1:0]  sw_i,
  output logic             timer_irq
);

  localparam logic [2:0] OFF_LED   = 3'd0;
  localparam logic [2:0] OFF_SW    = 3'd1;
  localparam logic [2:0] OFF_COUNT = 3'd2;
  localparam logic [2:0] OFF_CMP   = 3'd3;
  localparam logic [2:0] OFF_CTRL  = 3'd4;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  state_t           state;
  logic [SW_W-1:0]  sw_sync_p0;
  logic [SW_W-1:0]  sw_sync_p1;
  logic [31:0]      count;
  logic [31:0]      cmp;
  logic             en;
  logic             irq_en;
  logic             pend;

  logic [2:0]       offset;
  logic [31:0]      rd_value;
  logic             wr_fire;
  logic             match;
  logic             unused_addr_bits;

  assign offset           = io_mmio_addr[4:2];
  assign unused_addr_bits = ^{io_mmio_addr[31:5], io_mmio_addr[1:0]};

  // The write side effect lands on the same edge that samples req in IDLE;
  // req is ignored while the response is being presented.
  assign wr_fire = (state == IDLE) && io_mmio_req && io_mmio_we;

  // Match uses the pre-increment count and the EN value currently held,
  // so a CTRL write only influences matching from the following edge.
  assign match = en && (count == cmp);

  assign timer_irq = pend & irq_en;

  always_comb begin
    rd_value = '0;
    case (offset)
      OFF_LED:   rd_value = 32'(led_o);
      OFF_SW:    rd_value = 32'(sw_sync_p1);
      OFF_COUNT: rd_value = count;
      OFF_CMP:   rd_value = cmp;
      OFF_CTRL:  rd_value = {29'd0, pend, irq_en, en};
      default:   rd_value = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      io_mmio_ready <= 1'b0;
      io_mmio_rdata <= '0;
      led_o         <= '0;
      sw_sync_p0    <= '0;
      sw_sync_p1    <= '0;
      count         <= '0;
      cmp           <= 32'hFFFF_FFFF;
      en            <= 1'b0;
      irq_en        <= 1'b0;
      pend          <= 1'b0;
    end else begin
      // Stage p0 -> p1: two-flop synchronizer for the switch inputs
      sw_sync_p0 <= sw_i;
      sw_sync_p1 <= sw_sync_p0;

      if (en) begin
        count <= count + 32'd1;
      end

      // Later assignments win: a CPU write to COUNT beats the increment.
      if (wr_fire) begin
        case (offset)
          OFF_LED:   led_o <= io_mmio_wdata[LED_W-1:0];
          OFF_COUNT: count <= io_mmio_wdata;
          OFF_CMP:   cmp   <= io_mmio_wdata;
          OFF_CTRL: begin
            en     <= io_mmio_wdata[0];
            irq_en <= io_mmio_wdata[1];
            if (io_mmio_wdata[2]) begin
              pend <= 1'b0;
            end
          end
          default: ;
        endcase
      end

      // A match on the same edge beats a W1C clear.
      if (match) begin
        pend <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (io_mmio_req) begin
            state         <= RESP;
            io_mmio_ready <= 1'b1;
            io_mmio_rdata <= rd_value;
          end else begin
            io_mmio_ready <= 1'b0;
            io_mmio_rdata <= '0;
          end
        end
        RESP: begin
          state         <= IDLE;
          io_mmio_ready <= 1'b0;
          io_mmio_rdata <= '0;
        end
        default: begin
          state         <= IDLE;
          io_mmio_ready <= 1'b0;
          io_mmio_rdata <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_timer_regs.sv
// tb_io_timer_regs
//
// Directed bench for io_timer_regs with hand-computed expected values.
// Inputs are driven on the falling edge; outputs are sampled 1 ns after
// the rising edge.
module tb_io_timer_regs;

  logic        clk;
  logic        rst;
  logic        io_mmio_req;
  logic        io_mmio_we;
  logic [31:0] io_mmio_addr;
  logic [31:0] io_mmio_wdata;
  logic [31:0] io_mmio_rdata;
  logic        io_mmio_ready;
  logic [15:0] led_o;
  logic [15:0] sw_i;
  logic        timer_irq;

  int n_checks;
  int n_err;

  io_timer_regs #(
    .LED_W(16),
    .SW_W (16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .io_mmio_req  (io_mmio_req),
    .io_mmio_we   (io_mmio_we),
    .io_mmio_addr (io_mmio_addr),
    .io_mmio_wdata(io_mmio_wdata),
    .io_mmio_rdata(io_mmio_rdata),
    .io_mmio_ready(io_mmio_ready),
    .led_o        (led_o),
    .sw_i         (sw_i),
    .timer_irq    (timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One complete access: request, wait (bounded) for ready, release,
  // then confirm the pulse ended and rdata returned to 0.
  task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata);
    int   waited;
    logic seen;
    waited = 0;
    seen   = 1'b0;
    rdata  = '0;
    @(negedge clk);
    io_mmio_req   = 1'b1;
    io_mmio_we    = we;
    io_mmio_addr  = addr;
    io_mmio_wdata = wdata;
    while (!seen && waited < 4) begin
      @(posedge clk);
      #1;
      waited++;
      if (io_mmio_ready) begin
        seen  = 1'b1;
        rdata = io_mmio_rdata;
      end
    end
    check("ready_seen", 32'(seen), 32'd1);
    @(negedge clk);
    io_mmio_req = 1'b0;
    io_mmio_we  = 1'b0;
    @(posedge clk);
    #1;
    check("ready_pulse_end", 32'(io_mmio_ready), 32'd0);
    check("rdata_idle_zero", io_mmio_rdata, 32'd0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] dummy;
    bus(1'b1, addr, wdata, dummy);
  endtask

  task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    logic [31:0] got;
    bus(1'b0, addr, 32'd0, got);
    check(tag, got, exp);
  endtask

  initial begin
    logic [5:0] pattern;
    int         pulses;

    n_checks      = 0;
    n_err         = 0;
    rst           = 1'b1;
    io_mmio_req   = 1'b0;
    io_mmio_we    = 1'b0;
    io_mmio_addr  = '0;
    io_mmio_wdata = '0;
    sw_i          = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    check("rst_ready", 32'(io_mmio_ready), 32'd0);
    check("rst_rdata", io_mmio_rdata, 32'd0);
    check("rst_led",   32'(led_o), 32'd0);
    check("rst_irq",   32'(timer_irq), 32'd0);
    rd("rst_count", 32'h08, 32'd0);
    rd("rst_cmp",   32'h0C, 32'hFFFF_FFFF);
    rd("rst_ctrl",  32'h10, 32'd0);

    // LED write/read, upper bits dropped
    wr(32'h00, 32'h0000_A5A5);
    check("led_after_wr", 32'(led_o), 32'h0000_A5A5);
    rd("led_rd", 32'h00, 32'h0000_A5A5);
    wr(32'h00, 32'hFFFF_5A5A);
    check("led_trunc", 32'(led_o), 32'h0000_5A5A);
    rd("led_rd_trunc", 32'h00, 32'h0000_5A5A);
    wr(32'h00, 32'h0000_A5A5);

    // Switch input through the synchronizer; writes ignored
    sw_i = 16'h1234;
    repeat (3) @(posedge clk);
    rd("sw_rd", 32'h04, 32'h0000_1234);
    wr(32'h04, 32'h0000_FFFF);
    rd("sw_rd_after_wr", 32'h04, 32'h0000_1234);

    // Compare match: CTRL write at edge E, count pre-increment hits 10 at E+11
    wr(32'h0C, 32'd10);
    wr(32'h10, 32'h3);
    check("irq_before", 32'(timer_irq), 32'd0);
    repeat (9) @(posedge clk);
    #1;
    check("irq_e10", 32'(timer_irq), 32'd0);
    @(posedge clk);
    #1;
    check("irq_e11", 32'(timer_irq), 32'd1);
    rd("ctrl_pend", 32'h10, 32'h7);
    wr(32'h10, 32'h7);
    check("irq_cleared", 32'(timer_irq), 32'd0);
    rd("ctrl_after_clr", 32'h10, 32'h3);

    // Counter wrap; the write overrides the same-edge increment
    wr(32'h08, 32'hFFFF_FFFE);
    rd("count_ffff", 32'h08, 32'hFFFF_FFFF);
    rd("count_wrap", 32'h08, 32'h0000_0001);

    // Held request: one access per 2 cycles
    @(negedge clk);
    io_mmio_req  = 1'b1;
    io_mmio_we   = 1'b0;
    io_mmio_addr = 32'h00;
    pattern      = '0;
    pulses       = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      pattern[i] = io_mmio_ready;
      if (io_mmio_ready) pulses++;
    end
    @(negedge clk);
    io_mmio_req = 1'b0;
    @(posedge clk);
    #1;
    check("hold_pattern", 32'(pattern), 32'h15);
    check("hold_pulses", 32'(pulses), 32'd3);

    // Reserved offsets
    rd("rsvd_rd", 32'h18, 32'd0);
    wr(32'h14, 32'hFFFF_FFFF);
    rd("rsvd_led_kept", 32'h00, 32'h0000_A5A5);
    rd("rsvd_cmp_kept", 32'h0C, 32'd10);

    // Reset during RESP of a LED write
    @(negedge clk);
    io_mmio_req   = 1'b1;
    io_mmio_we    = 1'b1;
    io_mmio_addr  = 32'h00;
    io_mmio_wdata = 32'h0000_5A5A;
    @(posedge clk);
    #1;
    check("mid_ready", 32'(io_mmio_ready), 32'd1);
    check("mid_led", 32'(led_o), 32'h0000_5A5A);
    @(negedge clk);
    rst         = 1'b1;
    io_mmio_req = 1'b0;
    io_mmio_we  = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_ready", 32'(io_mmio_ready), 32'd0);
    check("mid_rst_led", 32'(led_o), 32'd0);
    check("mid_rst_irq", 32'(timer_irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rd("mid_rst_count", 32'h08, 32'd0);
    rd("mid_rst_cmp", 32'h0C, 32'hFFFF_FFFF);
    rd("mid_rst_ctrl", 32'h10, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
